operand_issue_ctrl: RTL and testbench

Upstream feeder for the registered A/B arithmetic stage. Buffers operand pairs from a valid/ready producer in a small FIFO. Issues one pair at a time on A/B and holds it stable for the stage latency. Captures the stage's Q result at the correct cycle and returns it on a valid/ready result port, so a non-pipelined consumer sees one result per accepted pair, in order.

---
 rtl/operand_issue_pkg.sv | 20 ++
 rtl/operand_issue_ctrl_if.sv | 35 +++
 rtl/operand_fifo.sv | 63 ++++++
 rtl/operand_issue_ctrl.sv | 124 ++++++++++++
 tb/tb_operand_issue_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/operand_issue_pkg.sv
// Shared types and defaults for the operand issue controller and its FIFO.
package operand_issue_pkg;

  localparam int DEF_DEPTH   = 4;
  localparam int DEF_LATENCY = 1;
  localparam int DEF_WIDTH   = 32;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] a;
    logic [DEF_WIDTH-1:0] b;
  } operand_pair_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESULT
  } issue_state_t;

endpackage

// File: rtl/operand_issue_ctrl_if.sv
// Producer, downstream-stage and result-port signals of operand_issue_ctrl.
interface operand_issue_ctrl_if
  import operand_issue_pkg::*;
#(
  parameter int P_WIDTH = DEF_WIDTH,
  parameter int P_DEPTH = DEF_DEPTH
);
  localparam int OCC_W = $clog2(P_DEPTH) + 1;

  logic               IN_VALID;
  logic               IN_READY;
  logic [P_WIDTH-1:0] IN_A;
  logic [P_WIDTH-1:0] IN_B;
  logic [P_WIDTH-1:0] A;
  logic [P_WIDTH-1:0] B;
  logic [P_WIDTH-1:0] Q;
  logic               RES_VALID;
  logic               RES_READY;
  logic [P_WIDTH-1:0] RES_DATA;
  logic [OCC_W-1:0]   OCCUPANCY;
  logic               BUSY;

  // The controller side.
  modport slave (
    input  IN_VALID, IN_A, IN_B, Q, RES_READY,
    output IN_READY, A, B, RES_VALID, RES_DATA, OCCUPANCY, BUSY
  );

  // Producer, downstream stage and consumer side.
  modport master (
    output IN_VALID, IN_A, IN_B, Q, RES_READY,
    input  IN_READY, A, B, RES_VALID, RES_DATA, OCCUPANCY, BUSY
  );

endinterface

// File: rtl/operand_fifo.sv
// Synchronous FIFO of operand pairs; full/empty come from the occupancy count.
module operand_fifo
  import operand_issue_pkg::*;
#(
  parameter int  P_DEPTH = DEF_DEPTH,
  parameter type pair_t  = operand_pair_t,
  localparam int PTR_W   = $clog2(P_DEPTH),
  localparam int OCC_W   = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  pair_t            push_data,
  input  logic             pop,
  output pair_t            pop_data,
  output logic             full,
  output logic             empty,
  output logic [OCC_W-1:0] occupancy
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             push_ok, pop_ok;
  pair_t            mem_q [P_DEPTH];

  assign full    = (occ_q == OCC_W'(P_DEPTH));
  assign empty   = (occ_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    occ_d = occ_q + OCC_W'(push_ok) - OCC_W'(pop_ok);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // NOTE: storage is not reset; occupancy guards every read, so the array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data  = mem_q[rd_ptr_q];
  assign occupancy = occ_q;

endmodule

// File: rtl/operand_issue_ctrl.sv
// Buffers operand pairs, issues one at a time onto A/B for the stage latency,
// and returns the captured Q on a valid/ready result port.
module operand_issue_ctrl
  import operand_issue_pkg::*;
#(
  parameter int P_DEPTH   = DEF_DEPTH,
  parameter int P_LATENCY = DEF_LATENCY,
  parameter int P_WIDTH   = DEF_WIDTH
) (
  input logic                 CLK,
  input logic                 RST_X,
  operand_issue_ctrl_if.slave bus
);

  localparam int OCC_W = $clog2(P_DEPTH) + 1;
  localparam int CNT_W = $clog2(P_LATENCY + 1);

  typedef struct packed {
    logic [P_WIDTH-1:0] a;
    logic [P_WIDTH-1:0] b;
  } pair_t;

  issue_state_t       state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [P_WIDTH-1:0] a_q, a_d;
  logic [P_WIDTH-1:0] b_q, b_d;
  logic [P_WIDTH-1:0] res_data_q, res_data_d;
  logic               res_valid_q, res_valid_d;
  logic               rdy_en_q, rdy_en_d;

  logic               in_ready, push, pop;
  logic               fifo_full, fifo_empty;
  pair_t              push_pair, head_pair;
  logic [OCC_W-1:0]   occupancy;

  // IN_READY stays low through reset and rises on the first edge after release.
  assign rdy_en_d    = 1'b1;
  assign in_ready    = rdy_en_q && !fifo_full;
  assign push        = bus.IN_VALID && in_ready;
  assign push_pair.a = bus.IN_A;
  assign push_pair.b = bus.IN_B;

  operand_fifo #(
    .P_DEPTH (P_DEPTH),
    .pair_t  (pair_t)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RST_X),
    .push      (push),
    .push_data (push_pair),
    .pop       (pop),
    .pop_data  (head_pair),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .occupancy (occupancy)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    pop         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = ISSUE;
      end
      ISSUE: begin
        pop     = 1'b1;
        a_d     = head_pair.a;
        b_d     = head_pair.b;
        cnt_d   = CNT_W'(P_LATENCY);
        state_d = WAIT;
      end
      WAIT: begin
        // Q for the held A/B is valid at the edge where the count runs out.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          res_valid_d = 1'b1;
          res_data_d  = bus.Q;
          state_d     = RESULT;
        end
      end
      RESULT: begin
        if (bus.RES_READY) begin
          res_valid_d = 1'b0;
          state_d     = fifo_empty ? IDLE : ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      rdy_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      rdy_en_q    <= rdy_en_d;
    end
  end

  assign bus.IN_READY  = in_ready;
  assign bus.A         = a_q;
  assign bus.B         = b_q;
  assign bus.RES_VALID = res_valid_q;
  assign bus.RES_DATA  = res_data_q;
  assign bus.OCCUPANCY = occupancy;
  assign bus.BUSY      = (state_q != IDLE);

endmodule

// File: tb/tb_operand_issue_ctrl.sv
// Self-checking bench for operand_issue_ctrl: directed scenarios plus random traffic,
// compared every cycle against a transaction-level model of the controller.
module tb_operand_issue_ctrl;

  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int LAT   = 3;

  logic clk = 1'b0;
  logic rst_x;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  operand_issue_ctrl_if #(.P_WIDTH(W), .P_DEPTH(DEPTH)) bus ();

  operand_issue_ctrl #(
    .P_DEPTH   (DEPTH),
    .P_LATENCY (LAT),
    .P_WIDTH   (W)
  ) dut (
    .CLK   (clk),
    .RST_X (rst_x),
    .bus   (bus)
  );

  // Downstream adder: the sum of an A/B pair is what Q shows when sampled LAT edges after A/B change.
  if (LAT == 1) begin : g_stage_comb
    assign bus.Q = bus.A + bus.B;
  end else begin : g_stage_pipe
    logic [W-1:0] pipe [LAT-1];
    always @(posedge clk or negedge rst_x) begin
      if (!rst_x) begin
        for (int i = 0; i < LAT - 1; i++) pipe[i] <= '0;
      end else begin
        pipe[0] <= bus.A + bus.B;
        for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
      end
    end
    assign bus.Q = pipe[LAT-2];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic [2*W-1:0] m_fifo [$];
  bit             m_rdy_en      = 1'b0;
  bit             m_issue_next  = 1'b0;
  bit             m_res_valid   = 1'b0;
  int             m_wait        = 0;
  logic [W-1:0]   m_a           = '0;
  logic [W-1:0]   m_b           = '0;
  logic [W-1:0]   m_res_data    = '0;

  function automatic logic m_in_ready();
    return m_rdy_en && (m_fifo.size() < DEPTH);
  endfunction

  function automatic logic m_busy();
    return m_issue_next || (m_wait > 0) || m_res_valid;
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    m_rdy_en     = 1'b0;
    m_issue_next = 1'b0;
    m_res_valid  = 1'b0;
    m_wait       = 0;
    m_a          = '0;
    m_b          = '0;
    m_res_data   = '0;
  endtask

  task automatic model_step();
    int             sz      = m_fifo.size();
    bit             do_push = bus.IN_VALID && m_rdy_en && (sz < DEPTH);
    logic [2*W-1:0] head;
    if (m_issue_next) begin
      head         = m_fifo.pop_front();
      m_a          = head[2*W-1:W];
      m_b          = head[W-1:0];
      m_wait       = LAT;
      m_issue_next = 1'b0;
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        m_res_valid = 1'b1;
        m_res_data  = m_a + m_b;
      end
    end else if (m_res_valid) begin
      if (bus.RES_READY) begin
        m_res_valid  = 1'b0;
        m_issue_next = (sz > 0);
      end
    end else begin
      m_issue_next = (sz > 0);
    end
    if (do_push) m_fifo.push_back({bus.IN_A, bus.IN_B});
    m_rdy_en = 1'b1;
  endtask

  always @(posedge clk or negedge rst_x) begin
    if (!rst_x) model_reset();
    else        model_step();
  end

  // Every cycle, away from the active edge, the DUT must match the model.
  always @(negedge clk) begin
    check("cmp_in_ready",  bus.IN_READY,  m_in_ready());
    check("cmp_a",         bus.A,         m_a);
    check("cmp_b",         bus.B,         m_b);
    check("cmp_res_valid", bus.RES_VALID, m_res_valid);
    check("cmp_res_data",  bus.RES_DATA,  m_res_data);
    check("cmp_occupancy", bus.OCCUPANCY, m_fifo.size());
    check("cmp_busy",      bus.BUSY,      m_busy());
  end

  // Results accepted by the consumer, in acceptance order.
  logic [W-1:0] got_q [$];
  always @(posedge clk) begin
    if (rst_x && bus.RES_VALID && bus.RES_READY) got_q.push_back(bus.RES_DATA);
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic accept();
    bus.RES_READY = 1'b1;
    step();
    bus.RES_READY = 1'b0;
  endtask

  task automatic push_one(input logic [W-1:0] a, input logic [W-1:0] b);
    int budget = 0;
    bit acc    = 1'b0;
    bus.IN_VALID = 1'b1;
    bus.IN_A     = a;
    bus.IN_B     = b;
    while (!acc && budget < 50) begin
      acc = bus.IN_READY;
      step();
      budget++;
    end
    bus.IN_VALID = 1'b0;
    if (!acc) check("push_timeout", bus.IN_READY, 1'b1);
  endtask

  task automatic wait_result(input int budget, output int cycles);
    cycles = 0;
    while (!bus.RES_VALID && cycles < budget) begin
      step();
      cycles++;
    end
    if (!bus.RES_VALID) check("result_timeout", bus.RES_VALID, 1'b1);
  endtask

  task automatic wait_count(input int n, input int budget);
    int c = 0;
    while (got_q.size() < n && c < budget) begin
      step();
      c++;
    end
    check("result_count", got_q.size(), n);
  endtask

  // ---------------- directed and random stimulus ----------------
  initial begin
    int cyc;
    int pushed;
    bit acc;

    bus.IN_VALID  = 1'b0;
    bus.IN_A      = '0;
    bus.IN_B      = '0;
    bus.RES_READY = 1'b0;
    rst_x         = 1'b1;
    #1 rst_x      = 1'b0;
    step();
    check("reset_in_ready",  bus.IN_READY,  1'b0);
    check("reset_occupancy", bus.OCCUPANCY, 0);
    check("reset_busy",      bus.BUSY,      1'b0);
    check("reset_res_valid", bus.RES_VALID, 1'b0);
    check("reset_a",         bus.A,         0);
    rst_x = 1'b1;
    step();
    check("in_ready_after_release", bus.IN_READY, 1'b1);

    // Single pair (3,5): A/B after edge t+2, result after edge t+2+LAT.
    bus.IN_VALID = 1'b1; bus.IN_A = 3; bus.IN_B = 5;
    step();
    bus.IN_VALID = 1'b0;
    step();
    step();
    check("issue_a", bus.A, 3);
    check("issue_b", bus.B, 5);
    repeat (LAT - 1) step();
    check("no_early_result", bus.RES_VALID, 1'b0);
    step();
    check("single_valid", bus.RES_VALID, 1'b1);
    check("single_data",  bus.RES_DATA,  8);

    // Backpressure for 10 cycles while a second pair waits in the FIFO.
    bus.IN_VALID = 1'b1; bus.IN_A = 11; bus.IN_B = 22;
    for (int i = 0; i < 10; i++) begin
      step();
      bus.IN_VALID = 1'b0;
      check("bp_data",  bus.RES_DATA,  8);
      check("bp_a",     bus.A,         3);
      check("bp_b",     bus.B,         5);
      check("bp_valid", bus.RES_VALID, 1'b1);
      check("bp_occ",   bus.OCCUPANCY, 1);
    end
    accept();
    check("accept_clears_valid", bus.RES_VALID, 1'b0);
    check("issue_after_accept",  bus.BUSY,      1'b1);
    check("ab_hold_until_issue", bus.A,         3);
    step();
    check("next_issue_a",   bus.A,         11);
    check("next_issue_occ", bus.OCCUPANCY, 0);
    wait_result(20, cyc);
    check("second_data", bus.RES_DATA, 33);
    accept();
    check("idle_after_drain", bus.BUSY, 1'b0);

    // Wrap-around sum and exact capture latency.
    bus.IN_VALID = 1'b1; bus.IN_A = 32'hFFFF_FFFF; bus.IN_B = 1;
    step();
    bus.IN_VALID = 1'b0;
    wait_result(20, cyc);
    check("wrap_latency", cyc, LAT + 2);
    check("wrap_data",    bus.RES_DATA, 0);
    accept();

    // Fill to full with the consumer stalled, then a held push.
    got_q.delete();
    pushed = 0;
    for (int k = 0; k < 20 && bus.OCCUPANCY != DEPTH; k++) begin
      bus.IN_VALID = 1'b1;
      bus.IN_A     = pushed + 1;
      bus.IN_B     = pushed + 1;
      acc          = bus.IN_READY;
      step();
      if (acc) pushed++;
    end
    check("full_in_ready",  bus.IN_READY,  1'b0);
    check("full_occupancy", bus.OCCUPANCY, DEPTH);
    bus.IN_A = pushed + 1;
    bus.IN_B = pushed + 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("held_occupancy", bus.OCCUPANCY, DEPTH);
    end
    bus.RES_READY = 1'b1;
    push_one(pushed + 1, pushed + 1);
    pushed++;
    wait_count(pushed, 300);
    for (int i = 0; i < pushed && i < got_q.size(); i++)
      check("fill_order", got_q[i], 2 * (i + 1));
    bus.RES_READY = 1'b0;
    step();

    // Same-edge push and pop at occupancy 2.
    got_q.delete();
    push_one(10, 1);
    push_one(20, 2);
    push_one(30, 3);
    wait_result(20, cyc);
    check("pp_occ_before", bus.OCCUPANCY, 2);
    accept();
    check("pp_in_issue", bus.BUSY, 1'b1);
    bus.IN_VALID = 1'b1; bus.IN_A = 40; bus.IN_B = 4;
    step();
    bus.IN_VALID = 1'b0;
    check("pp_occ_after", bus.OCCUPANCY, 2);
    bus.RES_READY = 1'b1;
    wait_count(4, 100);
    if (got_q.size() == 4) begin
      check("pp_res0", got_q[0], 11);
      check("pp_res1", got_q[1], 22);
      check("pp_res2", got_q[2], 33);
      check("pp_res3", got_q[3], 44);
    end
    bus.RES_READY = 1'b0;
    step();

    // Reset while waiting with two pairs queued.
    push_one(5, 6);
    push_one(7, 8);
    push_one(9, 10);
    check("wait_occ",  bus.OCCUPANCY, 2);
    check("wait_a",    bus.A,         5);
    check("wait_busy", bus.BUSY,      1'b1);
    #2 rst_x = 1'b0;
    #1;
    check("midrst_a",         bus.A,         0);
    check("midrst_b",         bus.B,         0);
    check("midrst_res_valid", bus.RES_VALID, 1'b0);
    check("midrst_occ",       bus.OCCUPANCY, 0);
    check("midrst_busy",      bus.BUSY,      1'b0);
    check("midrst_in_ready",  bus.IN_READY,  1'b0);
    step();
    step();
    rst_x = 1'b1;
    got_q.delete();
    bus.RES_READY = 1'b1;
    repeat (20) step();
    check("no_stale_result", got_q.size(), 0);
    push_one(7, 7);
    wait_count(1, 50);
    if (got_q.size() == 1) check("fresh_result", got_q[0], 14);

    // Random traffic; the per-cycle comparison does the checking.
    for (int c = 0; c < 400; c++) begin
      bus.RES_READY = ($urandom_range(0, 3) != 0);
      if (!bus.IN_VALID && $urandom_range(0, 2) == 0) begin
        bus.IN_VALID = 1'b1;
        bus.IN_A     = $urandom;
        bus.IN_B     = $urandom;
      end
      acc = bus.IN_VALID && bus.IN_READY;
      step();
      if (acc) bus.IN_VALID = 1'b0;
    end
    bus.IN_VALID  = 1'b0;
    bus.RES_READY = 1'b1;
    cyc = 0;
    while ((bus.BUSY || bus.OCCUPANCY != 0) && cyc < 300) begin
      step();
      cyc++;
    end
    check("drain_busy", bus.BUSY,      1'b0);
    check("drain_occ",  bus.OCCUPANCY, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
